// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: UART receive deframer behind the RX de-glitch filter.
// It detects the start edge on the oversample enable and samples each bit
// at mid-period. It checks parity and stop, then presents each character on
// a one-entry valid/ready register with error flags and an overrun pulse.
module uart_rx_deframer #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 samp_clk,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS + 1);

  // Tick count at which a data/parity/stop sample falls (one bit-time apart).
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  // Tick count in START after which the next tick is the start-bit mid-point.
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  // Receive side state
  state_t                 state_q, state_d;
  logic                   prev_q, prev_d;
  logic [CNT_W-1:0]       tick_cnt_q, tick_cnt_d;
  logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_err_q, par_err_d;

  // Output register state
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   parity_err_q, parity_err_d;
  logic                   overrun_q, overrun_d;

  // Handoff from the receive FSM to the output register
  logic                   char_done;
  logic                   stop_err;

  // Shared tick-counter helpers for the bit-period states
  logic                   sample_pt;
  logic [CNT_W-1:0]       tick_next;

  assign sample_pt = (tick_cnt_q == CNT_LAST);
  assign tick_next = sample_pt ? '0 : tick_cnt_q + 1'b1;

  // Receive FSM: start detect, mid-bit sampling, parity and stop checks.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    prev_d     = prev_q;
    tick_cnt_d = tick_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    par_err_d  = par_err_q;
    char_done  = 1'b0;
    stop_err   = 1'b0;

    if (samp_clk) begin
      prev_d = rx;
      unique case (state_q)
        S_IDLE: begin
          // Only a genuine high-to-low transition starts a frame, so a line
          // held low (break) must go high again before the next start.
          if (!rx && prev_q) begin
            state_d    = S_START;
            tick_cnt_d = '0;
          end
        end

        S_START: begin
          if (tick_cnt_q == CNT_HALF) begin
            tick_cnt_d = '0;
            if (rx) begin
              state_d = S_IDLE;          // glitch, not a real start bit
            end else begin
              state_d   = S_DATA;
              bit_idx_d = '0;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end

        S_DATA: begin
          tick_cnt_d = tick_next;
          if (sample_pt) begin
            for (int i = 0; i < DATA_BITS; i++) begin
              if (bit_idx_q == IDX_W'(i)) shift_d[i] = rx;
            end
            bit_idx_d = bit_idx_q + 1'b1;
            if (bit_idx_q == IDX_LAST) begin
              state_d = (PARITY != 0) ? S_PAR : S_STOP;
            end
          end
        end

        S_PAR: begin
          tick_cnt_d = tick_next;
          if (sample_pt) begin
            // Odd parity expects the data plus parity bit to XOR to 1.
            par_err_d = (((^shift_q) ^ rx) != (PARITY == 1));
            state_d   = S_STOP;
          end
        end

        S_STOP: begin
          tick_cnt_d = tick_next;
          if (sample_pt) begin
            char_done = 1'b1;
            stop_err  = ~rx;
            state_d   = S_IDLE;          // ready for a back-to-back start
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output register: load a finished character or drop it as an overrun,
  // and retire the held character on a handshake.
  always_comb begin
    data_d       = data_q;
    valid_d      = valid_q;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;
    overrun_d    = 1'b0;

    if (char_done) begin
      // A handshake on the same edge frees the slot, so no bubble is needed.
      if (!valid_q || ready) begin
        data_d       = shift_q;
        valid_d      = 1'b1;
        frame_err_d  = stop_err;
        parity_err_d = (PARITY != 0) ? par_err_q : 1'b0;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  // State registers; reset discards any partially received frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      prev_q       <= 1'b1;
      tick_cnt_q   <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      par_err_q    <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop update from the
      // pre-edge values, independent of statement order.
      state_q      <= state_d;
      prev_q       <= prev_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      par_err_q    <= par_err_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Self-checking bench for uart_rx_deframer: an 8N1 instance and an 8E1
// instance driven with bit-level frames, checked against a character model.
module tb_uart_rx_deframer;

  localparam int OS = 16;
  localparam int DB = 8;
  // Tick offset from the falling edge to the stop sample (no parity).
  localparam int STOP_TICK = OS / 2 + (DB + 1) * OS;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } char_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic samp_clk = 1'b0;
  logic rx = 1'b1;
  logic ready = 1'b0;
  logic rx_p = 1'b1;
  logic ready_p = 1'b1;

  logic [7:0] data, data_p;
  logic valid, frame_err, parity_err, overrun;
  logic valid_p, frame_err_p, parity_err_p, overrun_p;

  int total = 0;
  int bad = 0;
  int tick_idx = 0;        // number of samp_clk ticks seen so far
  int cons_mode = 0;       // 0 ready=1, 1 lazy consumer, 2 ready=0, 3 one-shot
  int ready_tick = -1;
  int div_cnt = 0;
  int cdelay = 0;

  char_t rx_q[$];
  char_t rxp_q[$];
  int    rise_q[$];
  int    ovr_q[$];
  int    valid_clks = 0;
  int    ovr_clks = 0;
  logic  valid_d1 = 1'b0;

  uart_rx_deframer #(.OVERSAMPLE(OS), .DATA_BITS(DB), .PARITY(0)) dut (
    .clk(clk), .rst_n(rst_n), .samp_clk(samp_clk), .rx(rx),
    .data(data), .valid(valid), .ready(ready),
    .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun)
  );

  uart_rx_deframer #(.OVERSAMPLE(OS), .DATA_BITS(DB), .PARITY(2)) dut_p (
    .clk(clk), .rst_n(rst_n), .samp_clk(samp_clk), .rx(rx_p),
    .data(data_p), .valid(valid_p), .ready(ready_p),
    .frame_err(frame_err_p), .parity_err(parity_err_p), .overrun(overrun_p)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (samp_clk) tick_idx <= tick_idx + 1;

  // Oversample strobe (every third clk) followed by the consumer's ready.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      div_cnt  = (div_cnt == 2) ? 0 : div_cnt + 1;
      samp_clk = (div_cnt == 0);
      case (cons_mode)
        0: ready = 1'b1;
        1: begin
          if (ready) ready = 1'b0;
          else if (valid) begin
            if (cdelay == 0) begin
              ready  = 1'b1;
              cdelay = $urandom_range(0, 5);
            end else cdelay--;
          end
        end
        3: ready = samp_clk && (tick_idx == ready_tick);
        default: ready = 1'b0;
      endcase
    end
  end

  // Monitor on the falling edge: transfers, valid rises, overrun pulses.
  always @(negedge clk) begin
    if (valid && ready) rx_q.push_back(char_t'({data, frame_err, parity_err}));
    if (valid_p && ready_p) rxp_q.push_back(char_t'({data_p, frame_err_p, parity_err_p}));
    if (valid && !valid_d1) rise_q.push_back(tick_idx - 1);
    if (overrun) ovr_q.push_back(tick_idx - 1);
    valid_d1   <= valid;
    valid_clks <= valid_clks + (valid ? 1 : 0);
    ovr_clks   <= ovr_clks + (overrun ? 1 : 0);
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected character from the bits on the wire: count ones for parity.
  function automatic char_t model(input logic [7:0] d, input bit pbit,
                                  input bit stopb, input int pmode);
    char_t c;
    int ones;
    ones = $countones(d) + int'(pbit);
    c.d  = d;
    c.fe = !stopb;
    c.pe = 1'b0;
    if (pmode == 1) c.pe = ((ones % 2) == 0);
    else if (pmode == 2) c.pe = ((ones % 2) == 1);
    return c;
  endfunction

  task automatic tick_wait();
    do @(posedge clk); while (samp_clk !== 1'b1);
  endtask

  // Hold one line at a level for n oversample ticks.
  task automatic hold_line(input bit sel, input bit val, input int n);
    if (sel) rx_p = val;
    else rx = val;
    repeat (n) tick_wait();
    #1;
  endtask

  // Drive one frame; p100 is the bit period in hundredths of a tick.
  task automatic send_frame(input bit sel, input logic [7:0] d, input bit has_par,
                            input bit pbit, input bit stopb, input int p100,
                            output int st);
    logic [10:0] bits;
    int n;
    bits = '0;
    for (int i = 0; i < 8; i++) bits[1 + i] = d[i];
    n = 9;
    if (has_par) begin
      bits[n] = pbit;
      n++;
    end
    bits[n] = stopb;
    n++;
    st = tick_idx;
    for (int i = 0; i < n; i++)
      hold_line(sel, bits[i], ((i + 1) * p100) / 100 - (i * p100) / 100);
  endtask

  task automatic test_reset();
    total++;
    if ({data, valid, frame_err, parity_err, overrun} !== 12'h0) begin
      $display("FAIL reset_outputs: got %h expected 000", {data, valid, frame_err, parity_err, overrun});
      bad++;
    end
    total++;
    if ({data_p, valid_p, frame_err_p, parity_err_p, overrun_p} !== 12'h0) begin
      $display("FAIL reset_outputs_p: got %h expected 000", {data_p, valid_p, frame_err_p, parity_err_p, overrun_p});
      bad++;
    end
    @(negedge clk) rst_n = 1'b1;
    hold_line(0, 1'b1, 20);
    total++;
    if (valid !== 1'b0 || rx_q.size() != 0) begin
      $display("FAIL idle_after_reset: valid=%b transfers=%0d expected 0", valid, rx_q.size());
      bad++;
    end
  endtask

  task automatic test_single();
    int st, vc0;
    char_t exp;
    cons_mode = 0;
    rx_q.delete();
    rise_q.delete();
    vc0 = valid_clks;
    send_frame(0, 8'h55, 0, 0, 1, 1600, st);
    hold_line(0, 1'b1, 32);
    exp = model(8'h55, 0, 1, 0);
    total++;
    if (rx_q.size() != 1) begin
      $display("FAIL single_count: got %0d expected 1", rx_q.size());
      bad++;
    end else if (rx_q[0] !== exp) begin
      $display("FAIL single_char: got %h expected %h", rx_q[0], exp);
      bad++;
    end
    total++;
    if (rise_q.size() != 1 || rise_q[0] - st != STOP_TICK) begin
      $display("FAIL single_valid_tick: got %0d expected %0d",
               (rise_q.size() != 0) ? rise_q[0] - st : -1, STOP_TICK);
      bad++;
    end
    total++;
    if (valid_clks - vc0 != 1) begin
      $display("FAIL single_valid_width: got %0d expected 1", valid_clks - vc0);
      bad++;
    end
  endtask

  task automatic test_back_to_back();
    char_t exp_q[$];
    logic [7:0] d;
    int st;
    cons_mode = 1;
    rx_q.delete();
    send_frame(0, 8'hA5, 0, 0, 1, 1600, st);
    exp_q.push_back(model(8'hA5, 0, 1, 0));
    send_frame(0, 8'h3C, 0, 0, 1, 1600, st);
    exp_q.push_back(model(8'h3C, 0, 1, 0));
    for (int k = 0; k < 2; k++) begin      // 2% slow, back-to-back
      d = 8'($urandom);
      send_frame(0, d, 0, 0, 1, 1632, st);
      exp_q.push_back(model(d, 0, 1, 0));
    end
    for (int k = 0; k < 4; k++) begin      // random gaps and +/-2% rate
      d = 8'($urandom);
      send_frame(0, d, 0, 0, 1, $urandom_range(1568, 1632), st);
      exp_q.push_back(model(d, 0, 1, 0));
      hold_line(0, 1'b1, $urandom_range(0, 20));
    end
    hold_line(0, 1'b1, 32);
    total++;
    if (rx_q.size() != exp_q.size()) begin
      $display("FAIL b2b_count: got %0d expected %0d", rx_q.size(), exp_q.size());
      bad++;
    end
    for (int k = 0; k < exp_q.size() && k < rx_q.size(); k++) begin
      total++;
      if (rx_q[k] !== exp_q[k]) begin
        $display("FAIL b2b_char%0d: got %h expected %h", k, rx_q[k], exp_q[k]);
        bad++;
      end
    end
  endtask

  task automatic test_false_start();
    int st;
    char_t exp;
    cons_mode = 0;
    rx_q.delete();
    rise_q.delete();
    hold_line(0, 1'b0, 4);
    hold_line(0, 1'b1, 24);
    total++;
    if (rx_q.size() != 0 || rise_q.size() != 0) begin
      $display("FAIL false_start: got %0d valid rises expected 0", rise_q.size());
      bad++;
    end
    send_frame(0, 8'h12, 0, 0, 1, 1600, st);
    hold_line(0, 1'b1, 32);
    exp = model(8'h12, 0, 1, 0);
    total++;
    if (rx_q.size() != 1 || rx_q[0] !== exp) begin
      $display("FAIL after_false_start: got %0d chars first %h expected 1 char %h",
               rx_q.size(), (rx_q.size() != 0) ? rx_q[0] : char_t'(0), exp);
      bad++;
    end
  endtask

  task automatic test_break();
    int st;
    char_t exp0, exp1;
    cons_mode = 0;
    rx_q.delete();
    rise_q.delete();
    send_frame(0, 8'h00, 0, 0, 0, 1600, st);
    hold_line(0, 1'b0, 20 * OS);
    exp0 = model(8'h00, 0, 0, 0);
    total++;
    if (rx_q.size() != 1 || rx_q[0] !== exp0) begin
      $display("FAIL break_char: got %0d chars first %h expected 1 char %h",
               rx_q.size(), (rx_q.size() != 0) ? rx_q[0] : char_t'(0), exp0);
      bad++;
    end
    total++;
    if (rise_q.size() != 1) begin
      $display("FAIL break_hold: got %0d valid rises expected 1", rise_q.size());
      bad++;
    end
    hold_line(0, 1'b1, 16);
    send_frame(0, 8'h7E, 0, 0, 1, 1600, st);
    hold_line(0, 1'b1, 32);
    exp1 = model(8'h7E, 0, 1, 0);
    total++;
    if (rx_q.size() != 2 || rx_q[1] !== exp1) begin
      $display("FAIL after_break: got %0d chars last %h expected 2 chars last %h",
               rx_q.size(), (rx_q.size() != 0) ? rx_q[rx_q.size() - 1] : char_t'(0), exp1);
      bad++;
    end
  endtask

  task automatic test_parity();
    char_t exp_q[$];
    logic [7:0] d;
    bit pb, sb;
    int st;
    rxp_q.delete();
    send_frame(1, 8'h03, 1, 1, 1, 1600, st);
    exp_q.push_back(model(8'h03, 1, 1, 2));
    hold_line(1, 1'b1, 4);
    send_frame(1, 8'h03, 1, 0, 1, 1600, st);
    exp_q.push_back(model(8'h03, 0, 1, 2));
    hold_line(1, 1'b1, 4);
    for (int k = 0; k < 6; k++) begin
      d  = 8'($urandom);
      pb = 1'($urandom);
      sb = ($urandom_range(0, 3) != 0);
      send_frame(1, d, 1, pb, sb, 1600, st);
      exp_q.push_back(model(d, pb, sb, 2));
      hold_line(1, 1'b1, $urandom_range(4, 12));
    end
    hold_line(1, 1'b1, 32);
    total++;
    if (rxp_q.size() != exp_q.size()) begin
      $display("FAIL parity_count: got %0d expected %0d", rxp_q.size(), exp_q.size());
      bad++;
    end
    for (int k = 0; k < exp_q.size() && k < rxp_q.size(); k++) begin
      total++;
      if (rxp_q[k] !== exp_q[k]) begin
        $display("FAIL parity_char%0d: got %h expected %h", k, rxp_q[k], exp_q[k]);
        bad++;
      end
    end
  endtask

  task automatic test_overrun();
    int st1, st2, st3, oc0;
    cons_mode = 2;
    rx_q.delete();
    ovr_q.delete();
    oc0 = ovr_clks;
    send_frame(0, 8'h11, 0, 0, 1, 1600, st1);
    send_frame(0, 8'h22, 0, 0, 1, 1600, st2);
    hold_line(0, 1'b1, 16);
    total++;
    if (ovr_clks - oc0 != 1) begin
      $display("FAIL overrun_pulses: got %0d expected 1", ovr_clks - oc0);
      bad++;
    end
    total++;
    if (ovr_q.size() != 1 || ovr_q[0] - st2 != STOP_TICK) begin
      $display("FAIL overrun_tick: got %0d expected %0d",
               (ovr_q.size() != 0) ? ovr_q[0] - st2 : -1, STOP_TICK);
      bad++;
    end
    total++;
    if (data !== 8'h11 || valid !== 1'b1) begin
      $display("FAIL overrun_hold: got data=%h valid=%b expected data=11 valid=1", data, valid);
      bad++;
    end
    // Handshake on exactly the stop-sample edge of the next character.
    ready_tick = tick_idx + STOP_TICK;
    cons_mode  = 3;
    send_frame(0, 8'h33, 0, 0, 1, 1600, st3);
    hold_line(0, 1'b1, 16);
    cons_mode = 2;
    total++;
    if (rx_q.size() != 1 || rx_q[0].d !== 8'h11) begin
      $display("FAIL same_edge_xfer: got %0d transfers first %h expected 1 transfer 11",
               rx_q.size(), (rx_q.size() != 0) ? rx_q[0].d : 8'h00);
      bad++;
    end
    total++;
    if (ovr_clks - oc0 != 1) begin
      $display("FAIL same_edge_overrun: got %0d pulses expected 1", ovr_clks - oc0);
      bad++;
    end
    total++;
    if (data !== 8'h33 || valid !== 1'b1 || frame_err !== 1'b0) begin
      $display("FAIL same_edge_load: got data=%h valid=%b fe=%b expected 33 1 0", data, valid, frame_err);
      bad++;
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    int st;
    char_t exp;
    cons_mode = 2;
    d = 8'($urandom);
    hold_line(0, 1'b0, OS);                 // start bit
    for (int i = 0; i < 3; i++) hold_line(0, d[i], OS);
    hold_line(0, d[3], OS / 2);             // halfway through data bit 3
    @(negedge clk);
    rst_n = 1'b0;
    rx    = 1'b1;
    #1;
    total++;
    if ({data, valid, frame_err, parity_err, overrun} !== 12'h0) begin
      $display("FAIL mid_reset_outputs: got %h expected 000", {data, valid, frame_err, parity_err, overrun});
      bad++;
    end
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    cons_mode = 0;
    rx_q.delete();
    hold_line(0, 1'b1, 20);
    d = 8'($urandom);
    send_frame(0, d, 0, 0, 1, 1600, st);
    hold_line(0, 1'b1, 32);
    exp = model(d, 0, 1, 0);
    total++;
    if (rx_q.size() != 1 || rx_q[0] !== exp) begin
      $display("FAIL after_mid_reset: got %0d chars first %h expected 1 char %h",
               rx_q.size(), (rx_q.size() != 0) ? rx_q[0] : char_t'(0), exp);
      bad++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_false_start();
    test_break();
    test_parity();
    test_overrun();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
